// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Producer-side hazard scoreboard for the 5-stage MIPS pipeline.
//            Tracks, per architectural register, how many cycles remain until
//            an in-flight result becomes forwardable, and stalls ID when a
//            source operand cannot yet be forwarded (load-use, multiply) or a
//            write-after-write would complete out of order.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            id_valid              - ID holds a real instruction
//            id_rs/id_rt           - source registers
//            id_use_rs/id_use_rt   - source read enables
//            id_rd, id_regwrite    - destination register and write enable
//            id_memread, id_mul    - instruction class (load / multiply)
//            ex_flush              - squash the ID instruction this cycle
//            stall                 - hold PC and IF/ID, bubble into ID/EX
//            pc_write, ifid_write  - ~stall
//            idex_bubble           - stall | ex_flush
//            busy_mask             - bit r set while register r is pending
//            stall_cnt             - saturating count of stalled cycles
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int LD_LAT  = 1,
    parameter int MUL_LAT = 4,
    parameter int CW      = 3,
    parameter int SCW     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [4:0]      id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_mul,
    input  logic            ex_flush,
    output logic            stall,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            idex_bubble,
    output logic [NREG-1:0] busy_mask,
    output logic [SCW-1:0]  stall_cnt
);

    localparam logic [CW-1:0] c_LD_LAT  = CW'(LD_LAT);
    localparam logic [CW-1:0] c_MUL_LAT = CW'(MUL_LAT);

    // Remaining cycles until each register's pending result is forwardable.
    // Register indices come straight from the 5-bit ID fields.
    logic [CW-1:0]  r_pend [NREG];
    logic [SCW-1:0] r_stall_cnt;

    logic [CW-1:0]  w_lat_new;
    logic           w_raw_a;
    logic           w_raw_b;
    logic           w_waw;
    logic           w_stall;
    logic           w_issue;
    logic           w_record;

    // Multiply takes priority over load when both class bits are set.
    always_comb begin
        w_lat_new = '0;
        if (id_mul)
            w_lat_new = c_MUL_LAT;
        else if (id_memread)
            w_lat_new = c_LD_LAT;
    end

    assign w_raw_a = id_use_rs && (id_rs != 5'd0) && (r_pend[id_rs] != '0);
    assign w_raw_b = id_use_rt && (id_rt != 5'd0) && (r_pend[id_rt] != '0);

    // A new write must not complete before an older write to the same
    // register; an ALU write (latency 0) may issue only once that entry has
    // drained, while equal-or-longer latency writes may overtake safely.
    assign w_waw   = id_regwrite && (id_rd != 5'd0) && (r_pend[id_rd] > w_lat_new);

    // Flush dominates: a squashed instruction never stalls the front end.
    assign w_stall  = id_valid && !ex_flush && (w_raw_a || w_raw_b || w_waw);
    assign w_issue  = id_valid && !ex_flush && !w_stall;
    assign w_record = w_issue && id_regwrite && (id_rd != 5'd0) && (w_lat_new != '0);

    assign stall       = w_stall;
    assign pc_write    = ~w_stall;
    assign ifid_write  = ~w_stall;
    assign idex_bubble = w_stall | ex_flush;
    assign stall_cnt   = r_stall_cnt;

    generate
        for (genvar g = 0; g < NREG; g++) begin : g_busy
            assign busy_mask[g] = (r_pend[g] != '0);
        end
    endgenerate

    // All entries count down; a recording issue overrides the countdown of
    // its own destination (later non-blocking assignment wins). An ALU
    // write to a still-pending register leaves the countdown untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_pend[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (r_pend[i] != '0)
                    r_pend[i] <= r_pend[i] - 1'b1;
            end
            if (w_record)
                r_pend[id_rd] <= w_lat_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Self-checking bench for hazard_scoreboard. A reference model
//            keeps, per register, the absolute cycle at which its pending
//            result becomes forwardable; remaining latency is derived from
//            that and the current cycle number. Two DUT instances share the
//            stimulus: a default one and one with a 2-bit stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int c_NREG    = 32;
    localparam int c_LD_LAT  = 1;
    localparam int c_MUL_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, id_mul, ex_flush;
    logic [4:0]  id_rs, id_rt, id_rd;

    logic        stall, pc_write, ifid_write, idex_bubble;
    logic [31:0] busy_mask;
    logic [15:0] stall_cnt;
    logic        stall_s, pc_write_s, ifid_write_s, idex_bubble_s;
    logic [31:0] busy_mask_s;
    logic [1:0]  stall_cnt_s;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_mul(id_mul),
        .ex_flush(ex_flush), .stall(stall), .pc_write(pc_write),
        .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.SCW(2)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_mul(id_mul),
        .ex_flush(ex_flush), .stall(stall_s), .pc_write(pc_write_s),
        .ifid_write(ifid_write_s), .idex_bubble(idex_bubble_s),
        .busy_mask(busy_mask_s), .stall_cnt(stall_cnt_s)
    );

    // ---------------- reference model ----------------
    int unsigned cycle;
    int unsigned ready [c_NREG];   // cycle from which the register is free
    int unsigned m_stalls;         // total stalled cycles since reset

    int tests  = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned pend_m(input logic [4:0] r);
        if (r == 5'd0 || ready[r] <= cycle) return 0;
        return ready[r] - cycle;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < c_NREG; i++) ready[i] = 0;
        m_stalls = 0;
    endfunction

    // Drive one ID cycle, check all outputs, advance one clock edge.
    task automatic step(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] rd, input logic rw,
                        input logic mr, input logic ml, input logic fl,
                        output logic stalled);
        int unsigned lat;
        logic m_stall, waw;
        logic [31:0] m_busy;
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_rd = rd; id_regwrite = rw; id_memread = mr; id_mul = ml; ex_flush = fl;
        #1;
        lat = ml ? c_MUL_LAT : (mr ? c_LD_LAT : 0);
        waw = rw && rd != 0 && pend_m(rd) > lat;
        m_stall = v && !fl && ((urs && pend_m(rs) != 0) || (urt && pend_m(rt) != 0) || waw);
        for (int i = 0; i < c_NREG; i++) m_busy[i] = (pend_m(5'(i)) != 0);
        check("stall", {63'd0, stall}, {63'd0, m_stall});
        check("pc_write", {63'd0, pc_write}, {63'd0, !m_stall});
        check("ifid_write", {63'd0, ifid_write}, {63'd0, !m_stall});
        check("idex_bubble", {63'd0, idex_bubble}, {63'd0, m_stall | fl});
        check("busy_mask", {32'd0, busy_mask}, {32'd0, m_busy});
        check("stall_cnt", {48'd0, stall_cnt}, 64'(m_stalls > 65535 ? 65535 : m_stalls));
        check("stall_s", {63'd0, stall_s}, {63'd0, m_stall});
        check("stall_cnt_s", {62'd0, stall_cnt_s}, 64'(m_stalls > 3 ? 3 : m_stalls));
        stalled = stall;
        @(posedge clk);
        if (m_stall) m_stalls++;
        if (v && !fl && !m_stall && rw && rd != 0 && lat != 0)
            ready[rd] = cycle + 1 + lat;
        cycle++;
        #1;
    endtask

    // Hold one instruction in ID until it leaves (bounded); returns stall count.
    task automatic run(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic ml, input logic fl,
                       output int nstall);
        logic s;
        nstall = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, rs, urs, rt, urt, rd, rw, mr, ml, fl, s);
            if (!s) return;
            nstall++;
        end
        check("run_timeout", 64'(nstall), 64'(0));
    endtask

    task automatic idle();
        logic s;
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, s);
    endtask

    initial begin
        int n;
        int unsigned cnt_before;
        logic s, held;
        logic v, urs, urt, rw, mr, ml, fl;
        logic [4:0] rs, rt, rd;

        cycle = 0;
        model_reset();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; id_mul = 0; ex_flush = 1;
        rst_n = 0;
        #3;
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_busy", {32'd0, busy_mask}, 64'd0);
        check("rst_bubble_follows_flush", {63'd0, idex_bubble}, 64'd1);
        @(posedge clk); #3 rst_n = 1;
        @(posedge clk); #1;

        // load-use: exactly one stall cycle
        run(5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, n);
        run(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 0, n);
        check("ld_use_stalls", 64'(n), 64'd1);
        check("ld_use_cnt", {48'd0, stall_cnt}, 64'd1);

        // ALU back-to-back: forwarding covers it
        run(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, n);
        run(5'd5, 1, 5'd5, 1, 5'd7, 1, 0, 0, 0, n);
        check("alu_alu_stalls", 64'(n), 64'd0);
        check("alu_busy", {32'd0, busy_mask}, 64'd0);

        // multiply dependent: MUL_LAT stalls
        run(5'd1, 1, 5'd2, 1, 5'd8, 1, 0, 1, 0, n);
        run(5'd8, 1, 5'd0, 1, 5'd9, 1, 0, 0, 0, n);
        check("mul_use_stalls", 64'(n), 64'(c_MUL_LAT));

        // WAW: ALU write behind a multiply waits for it to drain
        run(5'd1, 1, 5'd2, 1, 5'd8, 1, 0, 1, 0, n);
        run(5'd1, 1, 5'd2, 1, 5'd8, 1, 0, 0, 0, n);
        check("waw_stalls", 64'(n), 64'(c_MUL_LAT));
        check("waw_busy8", {63'd0, busy_mask[8]}, 64'd0);

        // register 0 never recorded; flushed dependent neither stalls nor counts
        run(5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 0, n);
        cnt_before = m_stalls;
        run(5'd0, 1, 5'd0, 1, 5'd3, 1, 0, 0, 0, n);
        check("r0_stalls", 64'(n), 64'd0);
        run(5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 0, 0, n);
        run(5'd5, 1, 5'd5, 1, 5'd6, 1, 1, 0, 1, n);
        check("flush_stalls", 64'(n), 64'd0);
        check("flush_cnt", 64'(m_stalls), 64'(cnt_before));

        // asynchronous reset in the middle of a multiply stall
        run(5'd1, 1, 5'd2, 1, 5'd8, 1, 0, 1, 0, n);
        step(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, s);
        check("pre_rst_stall", {63'd0, stall}, 64'd1);
        #2 rst_n = 0;
        #1;
        check("async_rst_stall", {63'd0, stall}, 64'd0);
        check("async_rst_busy", {32'd0, busy_mask}, 64'd0);
        check("async_rst_cnt", {48'd0, stall_cnt}, 64'd0);
        model_reset();
        @(posedge clk); #3 rst_n = 1;
        step(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, s);
        check("post_rst_no_stall", {63'd0, s}, 64'd0);

        // randomized traffic; a stalled instruction stays in ID
        held = 0;
        v = 0; rs = 0; rt = 0; rd = 0; urs = 0; urt = 0; rw = 0; mr = 0; ml = 0; fl = 0;
        for (int k = 0; k < 600; k++) begin
            if (!held) begin
                v   = ($urandom_range(0, 7) != 0);
                rs  = 5'($urandom_range(0, 5));
                rt  = 5'($urandom_range(0, 5));
                rd  = 5'($urandom_range(0, 5));
                urs = 1'($urandom);
                urt = 1'($urandom);
                rw  = ($urandom_range(0, 3) != 0);
                ml  = ($urandom_range(0, 5) == 0);
                mr  = ($urandom_range(0, 3) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            step(v, rs, urs, rt, urt, rd, rw, mr, ml, fl, s);
            held = s;
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX/MEM/WB forwarding logic in the 5-stage MIPS pipeline.
- Records every register write issued from ID into EX, together with the number of cycles until its result is forwardable.
- Stalls the ID stage whenever forwarding cannot yet supply a source operand (load-use, multi-cycle multiply) or a write-after-write ordering would break.
- Sits beside the ID/EX pipeline register; drives the PC, IF/ID write enables and the ID/EX bubble.

Parameters:
NREG, 32, architectural register count; register 0 is hardwired zero
LD_LAT, 1, stall cycles a load result imposes on a dependent instruction
MUL_LAT, 4, stall cycles a multiply result imposes on a dependent instruction
CW, 3, per-register countdown width; must hold max(LD_LAT, MUL_LAT)
SCW, 16, stall statistics counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction (not a bubble)
id_rs  in  5  source register A
id_rt  in  5  source register B
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_rd  in  5  destination register (already muxed rt/rd/31)
id_regwrite  in  1  instruction writes id_rd
id_memread  in  1  instruction is a load
id_mul  in  1  instruction is a multiply
ex_flush  in  1  squash the ID instruction this cycle; it does not issue
stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
pc_write  out  1  equals ~stall
ifid_write  out  1  equals ~stall
idex_bubble  out  1  equals stall | ex_flush
busy_mask  out  NREG  bit r set when pend[r] != 0
stall_cnt  out  SCW  saturating count of stalled cycles

Behaviour:
- State consists of pend[0..NREG-1] (CW bits each) and stall_cnt.
- On rst_n low, asynchronously: all pend = 0 and stall_cnt = 0. Outputs then read stall = 0, pc_write = 1, ifid_write = 1, busy_mask = 0. idex_bubble follows ex_flush.
- lat_new = MUL_LAT if id_mul; else LD_LAT if id_memread; else 0. id_mul takes priority over id_memread.
- raw_a = id_use_rs & id_rs != 0 & pend[id_rs] != 0. raw_b is the same check on rt.
- waw = id_regwrite & id_rd != 0 & pend[id_rd] > lat_new.
- stall = id_valid & ~ex_flush & (raw_a | raw_b | waw).
- stall is combinational from current state and ID inputs, with zero latency.
- issue = id_valid & ~ex_flush & ~stall.
- Each rising edge:
  - Every nonzero pend entry decrements by 1.
  - Then, if issue & id_regwrite & id_rd != 0 & lat_new != 0, pend[id_rd] <= lat_new. The issue write wins over the decrement of the same entry.
  - An ALU write (lat_new = 0) issued to a register whose entry is nonzero can only occur when waw is false. In that case the entry keeps decrementing; it is not cleared.
- Timing: a load issued at edge t yields pend = 1 during t+1. A dependent instruction in ID stalls for that one cycle, issues at t+2, and takes the value by MEM/WB forwarding.
- A multiply yields exactly MUL_LAT stall cycles for an immediate dependent.
- Register 0 is never recorded and never causes a stall.
- ex_flush has priority over stall. The squashed instruction neither records nor stalls, and decrements still occur.
- stall_cnt increments on each edge where stall = 1 and holds at all-ones.
- A reset asserted mid-stall clears all state immediately. The first cycle after release never stalls.

Test Plan:
1. lw $5 issued, next cycle add $6,$5,$1 in ID -> stall = 1 for exactly 1 cycle, pc_write = 0, idex_bubble = 1; add issues the next cycle; stall_cnt = 1.
2. add $5 then sub $7,$5,$5 back-to-back -> stall never asserted, busy_mask stays 0.
3. mul $8 then add $9,$8,$0 -> stall = 1 for 4 cycles; busy_mask[8] visible for 4 cycles after the mul issues.
4. mul $8 then ALU write to $8 -> waw stall while pend[8] > 0; after pend[8] reaches 0 the ALU write issues and pend[8] stays 0.
5. lw $0 then use of $0, and load-use with ex_flush = 1 on the dependent -> no stall, no record, stall_cnt unchanged.
6. Mid-mul-stall, drop rst_n asynchronously -> stall = 0 and busy_mask = 0 immediately. With SCW = 2 and 5 stalled cycles, stall_cnt saturates at 3.
